// File: rtl/midi_msg_parser.sv
`default_nettype none
// ============================================================================
// Module   : midi_msg_parser
// Brief    : MIDI byte-stream parser with running status, SysEx skipping,
//            realtime pass-through and a single-entry ready/valid output.
// Revision : 1.0 - initial release
// ============================================================================
module midi_msg_parser #(
    parameter int OMNI    = 1,
    parameter int CHANNEL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       frame_err,
    output logic       msg_valid,
    input  logic       msg_ready,
    output logic [2:0] msg_type,
    output logic [3:0] channel,
    output logic [6:0] data1,
    output logic [6:0] data2,
    output logic       overflow,
    output logic [7:0] err_cnt
);

    localparam logic [3:0] c_chan = CHANNEL[3:0];

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        SYSEX   = 2'd3
    } state_t;

    state_t     r_state;
    logic [7:0] r_status;
    logic       r_rs_valid;
    logic [6:0] r_d1;
    logic       r_msg_valid;
    logic [2:0] r_type;
    logic [3:0] r_chan;
    logic [6:0] r_data1;
    logic [6:0] r_data2;
    logic       r_overflow;
    logic [7:0] r_err_cnt;

    logic       w_good;
    logic       w_is_rt;
    logic       w_is_status;
    logic       w_is_data;
    logic       w_first;
    logic       w_need_one;
    logic       w_complete;
    logic       w_pass;
    logic       w_emit;
    logic [2:0] w_type;
    logic [3:0] w_chan;
    logic [6:0] w_data1;
    logic [6:0] w_data2;

    assign w_good      = byte_valid && !frame_err;
    assign w_is_rt     = (byte_in >= 8'hF8);
    assign w_is_status = byte_in[7] && (byte_in < 8'hF0);
    assign w_is_data   = !byte_in[7];
    // A data byte is a first data byte in WAIT_D1, or in IDLE under running status
    assign w_first     = (r_state == WAIT_D1) || ((r_state == IDLE) && r_rs_valid);
    assign w_need_one  = (r_status[7:5] == 3'b110);
    assign w_complete  = w_good && w_is_data &&
                         ((w_first && w_need_one) || (r_state == WAIT_D2));
    assign w_pass      = (OMNI != 0) || (r_status[3:0] == c_chan);
    assign w_emit      = (w_good && w_is_rt) || (w_complete && w_pass);

    always_comb begin
        w_type  = r_status[6:4];
        w_chan  = r_status[3:0];
        w_data1 = r_d1;
        w_data2 = byte_in[6:0];
        if (w_is_rt) begin
            w_type  = 3'd7;
            w_chan  = 4'd0;
            w_data1 = byte_in[6:0];
            w_data2 = 7'd0;
        end else if (w_first && w_need_one) begin
            w_data1 = byte_in[6:0];
            w_data2 = 7'd0;
        end else if ((r_status[7:4] == 4'h9) && (byte_in[6:0] == 7'd0)) begin
            // Note-on with zero velocity is reported as note-off
            w_type = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_status    <= 8'd0;
            r_rs_valid  <= 1'b0;
            r_d1        <= 7'd0;
            r_msg_valid <= 1'b0;
            r_type      <= 3'd0;
            r_chan      <= 4'd0;
            r_data1     <= 7'd0;
            r_data2     <= 7'd0;
            r_overflow  <= 1'b0;
            r_err_cnt   <= 8'd0;
        end else begin
            if (byte_valid) begin
                if (frame_err) begin
                    r_state    <= IDLE;
                    r_rs_valid <= 1'b0;
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end else if (w_is_rt) begin
                    r_state <= r_state;
                end else if (w_is_status) begin
                    r_status   <= byte_in;
                    r_rs_valid <= 1'b1;
                    r_state    <= WAIT_D1;
                end else if (byte_in == 8'hF0) begin
                    r_rs_valid <= 1'b0;
                    r_state    <= SYSEX;
                end else if (byte_in[7]) begin
                    r_rs_valid <= 1'b0;
                    r_state    <= IDLE;
                end else begin
                    case (r_state)
                        IDLE, WAIT_D1: begin
                            if (w_first) begin
                                r_d1    <= byte_in[6:0];
                                r_state <= w_need_one ? WAIT_D1 : WAIT_D2;
                            end
                        end
                        WAIT_D2: r_state <= WAIT_D1;
                        default: r_state <= r_state;
                    endcase
                end
            end

            // A held, unaccepted message wins; a new completion is lost
            if (r_msg_valid && !msg_ready) begin
                if (w_emit) begin
                    r_overflow <= 1'b1;
                end
            end else if (w_emit) begin
                r_msg_valid <= 1'b1;
                r_type      <= w_type;
                r_chan      <= w_chan;
                r_data1     <= w_data1;
                r_data2     <= w_data2;
            end else begin
                r_msg_valid <= 1'b0;
            end
        end
    end

    assign msg_valid = r_msg_valid;
    assign msg_type  = r_type;
    assign channel   = r_chan;
    assign data1     = r_data1;
    assign data2     = r_data2;
    assign overflow  = r_overflow;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire
